// File: rtl/defines.sv
// Shared RV32 execute-stage definitions: data width, M-extension divide
// encodings and the divider's state type and helpers.
package defines;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_t;

  // funct3 encodings of the divide group (funct3[2] = 1)
  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  // One quotient bit per CALC cycle
  localparam int DIV_CYCLES = XLEN;
  localparam int DIV_CNT_W  = $clog2(DIV_CYCLES);

  // Partial remainder and quotient after one restoring iteration
  typedef struct packed {
    data_t rem;
    data_t quo;
  } div_step_t;

  // Two's-complement magnitude for signed operands, raw value otherwise.
  // 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
  function automatic data_t abs_val(data_t value, logic is_signed);
    if (is_signed && value[XLEN-1]) begin
      return (~value) + 1'b1;
    end
    return value;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring.
// Divide-by-zero and signed overflow bypass the iteration and finish in
// one cycle. Outputs are decoded from state or come straight from flops.
module div_unit
  import defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  data_t       rs1,
  input  data_t       rs2,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output data_t       result
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_CYCLES - 1);
  localparam data_t                INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor; the 33rd bit of the trial is its
  // sign and decides whether the subtraction is kept.
  function automatic div_step_t div_step(data_t rem, logic dvd_msb, data_t quo, data_t dvs);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    div_step_t     nxt;
    shifted = {rem, dvd_msb};
    trial   = shifted - {1'b0, dvs};
    if (!trial[XLEN]) begin
      nxt.rem = trial[XLEN-1:0];
      nxt.quo = {quo[XLEN-2:0], 1'b1};
    end else begin
      nxt.rem = shifted[XLEN-1:0];
      nxt.quo = {quo[XLEN-2:0], 1'b0};
    end
    return nxt;
  endfunction

  div_state_t           r_state;
  div_state_t           w_state_next;
  logic [DIV_CNT_W-1:0] r_cnt;
  data_t                r_rem;
  data_t                r_quo;
  data_t                r_dvd;
  data_t                r_dvs;
  data_t                r_result;
  logic                 r_is_rem;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic                 w_is_signed;
  logic                 w_is_rem;
  logic                 w_div0;
  logic                 w_ovf;
  logic                 w_fast;
  logic                 w_accept;
  data_t                w_fast_res;
  div_step_t            w_step;
  data_t                w_final;

  // Decode the request; flush suppresses acceptance in the same cycle
  always_comb begin
    w_is_signed = (funct3 == DIV) || (funct3 == REM);
    w_is_rem    = (funct3 == REM) || (funct3 == REMU);
    w_div0      = (rs2 == '0);
    w_ovf       = w_is_signed && (rs1 == INT_MIN) && (rs2 == '1);
    w_fast      = w_div0 || w_ovf;
    w_accept    = start && funct3[2] && (r_state == DIV_IDLE) && !flush;
    if (w_div0) begin
      w_fast_res = w_is_rem ? rs1 : '1;
    end else begin
      w_fast_res = w_is_rem ? '0 : INT_MIN;
    end
  end

  // Current iteration and the sign-corrected result of the final one
  always_comb begin
    w_step = div_step(r_rem, r_dvd[XLEN-1], r_quo, r_dvs);
    if (r_is_rem) begin
      w_final = r_neg_r ? (~w_step.rem) + 1'b1 : w_step.rem;
    end else begin
      w_final = r_neg_q ? (~w_step.quo) + 1'b1 : w_step.quo;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush returns to IDLE from any state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      DIV_IDLE: begin
        if (w_accept) begin
          w_state_next = w_fast ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (r_cnt == '0) begin
          w_state_next = DIV_DONE;
        end
      end
      DIV_DONE: w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
    if (flush) begin
      w_state_next = DIV_IDLE;
    end
  end

  // Status outputs decoded from state only
  always_comb begin
    ready = (r_state == DIV_IDLE);
    busy  = (r_state == DIV_CALC) || (r_state == DIV_DONE);
    done  = (r_state == DIV_DONE);
  end

  // Datapath: operand capture, iteration, and result update on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      unique case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_is_rem <= w_is_rem;
            r_neg_q  <= w_is_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            r_neg_r  <= w_is_signed && rs1[XLEN-1];
            if (w_fast) begin
              r_result <= w_fast_res;
            end else begin
              r_dvd <= abs_val(rs1, w_is_signed);
              r_dvs <= abs_val(rs2, w_is_signed);
              r_rem <= '0;
              r_quo <= '0;
              r_cnt <= CNT_LAST;
            end
          end
        end
        DIV_CALC: begin
          r_rem <= w_step.rem;
          r_quo <= w_step.quo;
          r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!flush) begin
            // a flushed operation must leave the previous result intact
            r_result <= w_final;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes expected results and
// expected status snapshots, a separate monitor compares every cycle.
module tb_div_unit;
  import defines::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       flush;
  logic [2:0] funct3;
  data_t      rs1;
  data_t      rs2;
  logic       ready;
  logic       busy;
  logic       done;
  data_t      result;

  always #5 clk = ~clk;

  div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  int   cyc = 0;
  logic rst_seen;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  typedef struct {
    int         cyc;
    data_t      res;
    logic [2:0] f3;
    data_t      a;
    data_t      b;
  } done_exp_t;

  typedef struct {
    int    cyc;
    logic  rdy;
    logic  bsy;
    logic  dn;
    logic  chk_res;
    data_t res;
    int    tag;
  } stat_exp_t;

  done_exp_t done_q[$];
  stat_exp_t stat_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: RISC-V M-extension divide semantics in plain arithmetic
  function automatic data_t ref_result(logic [2:0] f3, data_t a, data_t b);
    int  sa;
    int  sb;
    bit  ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      DIV:  if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return data_t'(sa / sb);
      DIVU: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      REM:  if (b == 0) return a; else if (ovf) return 32'h0; else return data_t'(sa % sb);
      REMU: if (b == 0) return a; else return a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_fast(logic [2:0] f3, data_t a, data_t b);
    return (b == 0) || (((f3 == DIV) || (f3 == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  task automatic push_stat(input int c, input logic r, input logic b, input logic d,
                           input logic cr, input data_t res, input int tag);
    stat_exp_t s;
    s.cyc = c; s.rdy = r; s.bsy = b; s.dn = d; s.chk_res = cr; s.res = res; s.tag = tag;
    stat_q.push_back(s);
  endtask

  // Issue one request at a negedge once ready; returns the issue cycle
  task automatic issue(input logic [2:0] f3, input data_t a, input data_t b,
                       input bit expect_it, output int n);
    int        k;
    int        lat;
    bit        fast;
    done_exp_t e;
    k = 0;
    while (!ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ready) push_stat(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 99);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    n = cyc;
    if (expect_it) begin
      fast  = is_fast(f3, a, b);
      lat   = fast ? 1 : 33;
      e.cyc = n + lat; e.res = ref_result(f3, a, b); e.f3 = f3; e.a = a; e.b = b;
      done_q.push_back(e);
      push_stat(n + 1, 1'b0, 1'b1, fast, 1'b0, '0, 1);
      push_stat(n + lat + 1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 2);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: all comparisons happen here, once per cycle at negedge
  initial begin : monitor
    logic      prev_done;
    data_t     prev_res;
    done_exp_t e;
    stat_exp_t s;
    prev_done = 1'b0;
    prev_res  = '0;
    forever begin
      @(negedge clk);
      checks++;
      if (ready && busy) begin
        errors++;
        $display("FAIL excl cyc=%0d ready=%b busy=%b want not both", cyc, ready, busy);
      end
      if (done) begin
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL done_twice cyc=%0d", cyc);
        end
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d result=%h want no done", cyc, result);
        end else begin
          e = done_q.pop_front();
          if (result !== e.res || cyc != e.cyc) begin
            errors++;
            $display("FAIL txn f3=%b a=%h b=%h result=%h want %h cyc=%0d want %0d",
                     e.f3, e.a, e.b, result, e.res, cyc, e.cyc);
          end else begin
            $display("txn f3=%b a=%h b=%h result=%h cyc=%0d", e.f3, e.a, e.b, result, cyc);
          end
        end
      end else if (!rst_seen) begin
        checks++;
        if (result !== prev_res) begin
          errors++;
          $display("FAIL result_hold cyc=%0d result=%h want %h", cyc, result, prev_res);
        end
      end
      if (done_q.size() > 0 && cyc > done_q[0].cyc) begin
        checks++;
        errors++;
        e = done_q.pop_front();
        $display("FAIL done_timeout f3=%b a=%h b=%h no done by cyc %0d", e.f3, e.a, e.b, e.cyc);
      end
      while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
        s = stat_q.pop_front();
        checks++;
        if (s.cyc != cyc || ready !== s.rdy || busy !== s.bsy || done !== s.dn ||
            (s.chk_res && result !== s.res)) begin
          errors++;
          $display("FAIL status tag=%0d cyc=%0d (want %0d) rdy/bsy/dn=%b%b%b want %b%b%b result=%h want %h",
                   s.tag, cyc, s.cyc, ready, busy, done, s.rdy, s.bsy, s.dn, result, s.res);
        end
      end
      prev_done = done;
      prev_res  = result;
    end
  end

  // Driver: directed cases, ignored-input cases, then random traffic
  initial begin : driver
    logic [2:0] d_f3 [9];
    data_t      d_a  [9];
    data_t      d_b  [9];
    int         n;
    int         mode;
    logic [2:0] f3;
    data_t      a;
    data_t      b;

    d_f3[0] = DIVU; d_a[0] = 32'd100;        d_b[0] = 32'd7;
    d_f3[1] = REMU; d_a[1] = 32'd100;        d_b[1] = 32'd7;
    d_f3[2] = DIV;  d_a[2] = 32'hFFFF_FFF9;  d_b[2] = 32'd2;
    d_f3[3] = REM;  d_a[3] = 32'hFFFF_FFF9;  d_b[3] = 32'd2;
    d_f3[4] = REM;  d_a[4] = 32'hFFFF_FFF9;  d_b[4] = 32'hFFFF_FFFE;
    d_f3[5] = DIV;  d_a[5] = 32'h0000_1234;  d_b[5] = 32'd0;
    d_f3[6] = REMU; d_a[6] = 32'h0000_1234;  d_b[6] = 32'd0;
    d_f3[7] = DIV;  d_a[7] = 32'h8000_0000;  d_b[7] = 32'hFFFF_FFFF;
    d_f3[8] = REM;  d_a[8] = 32'h8000_0000;  d_b[8] = 32'hFFFF_FFFF;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_stat(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b1, '0, 0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      issue(d_f3[i], d_a[i], d_b[i], 1'b1, n);
    end

    // flush mid-CALC: no done, ready the next cycle, then a clean op
    issue(DIVU, 32'd50, 32'd5, 1'b0, n);
    while (cyc < n + 10) @(negedge clk);
    flush = 1'b1;
    push_stat(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 3);
    @(negedge clk);
    flush = 1'b0;
    issue(DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1, n);

    // MUL-group start is ignored
    while (!ready) @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd3;
    push_stat(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 5);
    @(negedge clk);
    start = 1'b0;

    // start while busy is ignored; original result must survive
    issue(DIVU, 32'd100, 32'd7, 1'b1, n);
    while (cyc < n + 5) @(negedge clk);
    start = 1'b1; funct3 = DIV; rs1 = $urandom; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;

    // reset mid-CALC
    issue(DIVU, 32'd100, 32'd7, 1'b0, n);
    while (cyc < n + 5) @(negedge clk);
    rst = 1'b1;
    push_stat(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b1, '0, 4);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      f3   = 3'(4 + $urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 30); end
        3: b = data_t'(-int'($urandom_range(1, 30)));
        4: a = 32'h8000_0000;
        default: ;
      endcase
      issue(f3, a, b, 1'b1, n);
    end

    repeat (40) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
